// File: rtl/deck_controller.sv
// deck_controller: restarts and seeds the shuffler, buffers its 52-card stream, and serves round-robin draws.
// Optional DECK_CARD_VALUE_EN adds a registered blackjack card_value output.
module deck_controller #(
  parameter int DECK_SIZE = 52,
  parameter int RESHUFFLE_THRESH = 15,
  parameter logic [5:0] DEFAULT_SEED = 6'b101011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_round,
  input  logic       player_req,
  input  logic       dealer_req,
  input  logic       load_flag,
  input  logic [5:0] card_in,
  output logic       shuffle_rst,
  output logic       shuffle_flag,
  output logic [5:0] seed,
  output logic       player_gnt,
  output logic       dealer_gnt,
  output logic [5:0] card_out,
  output logic       card_valid,
  output logic       card_dest,
  output logic [5:0] remaining,
  output logic       ready,
`ifdef DECK_CARD_VALUE_EN
  output logic [3:0] card_value,
`endif
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, RESTART, SHUFFLE, LOAD, READY} state_t;
  localparam logic [5:0] DS = 6'(DECK_SIZE);
  localparam logic [5:0] TH = 6'(RESHUFFLE_THRESH);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, seed_q, seed_d, wr_q, wr_d, rd_q, rd_d, rem_q, rem_d, card_q, card_d;
  logic [6:0] ld_q, ld_d;
  logic rr_q, rr_d, pg_q, pg_d, dg_q, dg_d, valid_q, valid_d, dest_q, dest_d, cap, pick;
  logic [5:0] deck_q [DECK_SIZE];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 6'd1;
    seed_d = seed_q;
    ld_d = ld_q;
    wr_d = wr_q;
    rd_d = rd_q;
    rem_d = rem_q;
    rr_d = rr_q;
    pg_d = 1'b0;
    dg_d = 1'b0;
    valid_d = 1'b0;
    card_d = card_q;
    dest_d = dest_q;
    cap = 1'b0;
    pick = 1'b0;
    case (state_q)
      IDLE: if (new_round) state_d = RESTART;
      RESTART: begin
        state_d = SHUFFLE;
        wr_d = 6'd0;
        rd_d = 6'd0;
      end
      SHUFFLE: if (load_flag) begin
        state_d = LOAD;
        ld_d = 7'd1;
      end
      LOAD: if (!load_flag) state_d = RESTART;
      else begin
        ld_d = ld_q + 7'd1;
        // the shuffler holds each card for two load cycles; take it on the odd one
        if (ld_q[0]) begin
          cap = 1'b1;
          wr_d = wr_q + 6'd1;
          if (wr_q == DS - 6'd1) begin
            state_d = READY;
            rem_d = DS;
            rd_d = 6'd0;
          end
        end
      end
      READY: if (new_round) begin
        if (rem_q < TH) state_d = RESTART;
      end else if (rem_q == 6'd0) state_d = RESTART;
      else if (player_req || dealer_req) begin
        pick = dealer_req && (!player_req || rr_q);
        rr_d = (player_req && dealer_req) ? !rr_q : rr_q;
        pg_d = !pick;
        dg_d = pick;
        valid_d = 1'b1;
        card_d = deck_q[rd_q];
        dest_d = pick;
        rd_d = rd_q + 6'd1;
        rem_d = rem_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RESTART && state_q != RESTART) begin
      seed_d = cnt_q == 6'd0 ? DEFAULT_SEED : cnt_q;
      rem_d = 6'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 6'd1;
      seed_q <= 6'd0;
      ld_q <= 7'd0;
      wr_q <= 6'd0;
      rd_q <= 6'd0;
      rem_q <= 6'd0;
      rr_q <= 1'b0;
      pg_q <= 1'b0;
      dg_q <= 1'b0;
      valid_q <= 1'b0;
      card_q <= 6'd0;
      dest_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      seed_q <= seed_d;
      ld_q <= ld_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rem_q <= rem_d;
      rr_q <= rr_d;
      pg_q <= pg_d;
      dg_q <= dg_d;
      valid_q <= valid_d;
      card_q <= card_d;
      dest_q <= dest_d;
    end
  always_ff @(posedge clk)
    if (cap) deck_q[wr_q] <= card_in;
`ifdef DECK_CARD_VALUE_EN
  logic [3:0] rank, val_q, val_d;
  always_comb begin
    rank = 4'(card_d % 6'd13);
    val_d = rank == 4'd0 ? 4'd1 : rank < 4'd10 ? rank + 4'd1 : 4'd10;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val_q <= 4'd0;
    else val_q <= val_d;
  assign card_value = val_q;
`endif
  assign shuffle_rst = state_q == RESTART;
  assign shuffle_flag = state_q == SHUFFLE || state_q == LOAD;
  assign busy = shuffle_flag;
  assign ready = state_q == READY;
  assign seed = seed_q;
  assign player_gnt = pg_q;
  assign dealer_gnt = dg_q;
  assign card_out = card_q;
  assign card_valid = valid_q;
  assign card_dest = dest_q;
  assign remaining = rem_q;
endmodule

// File: tb/tb_deck_controller.sv
// tb_deck_controller: random draws against a deck/queue model with a shuffler model; a monitor scoreboards every cycle.
module tb_deck_controller;
  logic clk = 0, rst_n = 0, new_round = 0, player_req = 0, dealer_req = 0, load_flag = 0;
  logic [5:0] card_in = 0;
  logic shuffle_rst, shuffle_flag, player_gnt, dealer_gnt, card_valid, card_dest, ready, busy;
  logic [5:0] seed, card_out, remaining;
`ifdef DECK_CARD_VALUE_EN
  logic [3:0] card_value;
`endif
  always #5 clk = ~clk;
  deck_controller dut (
    .clk(clk), .rst_n(rst_n), .new_round(new_round), .player_req(player_req), .dealer_req(dealer_req),
    .load_flag(load_flag), .card_in(card_in), .shuffle_rst(shuffle_rst), .shuffle_flag(shuffle_flag),
    .seed(seed), .player_gnt(player_gnt), .dealer_gnt(dealer_gnt), .card_out(card_out),
    .card_valid(card_valid), .card_dest(card_dest), .remaining(remaining), .ready(ready),
`ifdef DECK_CARD_VALUE_EN
    .card_value(card_value),
`endif
    .busy(busy)
  );
  typedef struct {int card; bit dest;} exp_t;
  exp_t sbq[$];
  int m_deck[$];
  int perm[52];
  int checks = 0, errors = 0;
  int exp_seed = 0, gen = 0, li = 0, nedge = 0;
  bit m_ready = 0, m_idle = 1, rr = 0, first_perm = 1, exp_rst = 0, fault = 0, ld_active = 0;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask
  function automatic int val_of(input int c);
    int r = c % 13;
    return r == 0 ? 1 : r < 10 ? r + 1 : 10;
  endfunction
  task automatic trigger();
    int v = (nedge + 1) % 64;
    exp_rst = 1;
    m_ready = 0;
    m_deck.delete();
    exp_seed = v == 0 ? 43 : v;
  endtask
  task automatic build_perm();
    for (int i = 0; i < 52; i++) perm[i] = first_perm ? 51 - i : i;
    if (!first_perm)
      for (int i = 51; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
    first_perm = 0;
  endtask
  task automatic model_reset();
    m_ready = 0; m_idle = 1; rr = 0; exp_rst = 0; gen = 0; ld_active = 0; li = 0; fault = 0;
    load_flag = 0; player_req = 0; dealer_req = 0; new_round = 0;
    sbq.delete();
    m_deck.delete();
  endtask
  task automatic tick(input bit p, input bit d, input bit nr);
    @(negedge clk);
    player_req = p; dealer_req = d; new_round = nr; exp_rst = 0;
    if (m_idle && nr) begin
      m_idle = 0;
      trigger();
    end else if (m_ready) begin
      if (nr) begin
        if (m_deck.size() < 15) trigger();
      end else if (m_deck.size() == 0) trigger();
      else if (p || d) begin
        bit pk;
        exp_t e;
        pk = d && (!p || rr);
        if (p && d) rr = !rr;
        e.card = m_deck.pop_front();
        e.dest = pk;
        sbq.push_back(e);
      end
    end
    if (shuffle_rst) begin
      build_perm();
      gen = 1; ld_active = 0; load_flag = 0;
    end else if (gen > 0) begin
      if (shuffle_flag) gen++;
      if (gen == 5) begin
        gen = 0; ld_active = 1; li = 0; load_flag = 1; card_in = 6'(perm[0]);
      end
    end else if (ld_active) begin
      li++;
      if (li == (fault ? 20 : 104)) begin
        ld_active = 0; load_flag = 0;
        if (fault) begin
          fault = 0;
          trigger();
        end
      end else begin
        card_in = 6'(perm[li / 2]);
        if (li == 103) begin
          m_ready = 1;
          foreach (perm[i]) m_deck.push_back(perm[i]);
        end
      end
    end
  endtask
  task automatic wait_ready(input bit p);
    for (int k = 0; k < 400 && !m_ready; k++) tick(p, 0, 0);
    if (!m_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got 0 expected 1");
    end
  endtask
  task automatic wait_count(input int target);
    for (int k = 0; k < 70 && ((nedge + 2) % 64) != target; k++) tick(0, 0, 0);
    tick(0, 0, 1);
  endtask
  task automatic draw_below(input int lim);
    for (int k = 0; k < 2000 && m_ready && m_deck.size() >= lim; k++) tick($urandom % 2, $urandom % 2, 0);
  endtask
  task automatic chk_reset();
    chk("reset_outputs", {shuffle_rst, shuffle_flag, seed, player_gnt, dealer_gnt, card_out, card_valid,
                          card_dest, remaining, ready, busy}, 0);
`ifdef DECK_CARD_VALUE_EN
    chk("reset_card_value", card_value, 0);
`endif
  endtask
  always @(posedge clk)
    if (!rst_n) nedge = 0;
    else nedge++;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("ready", ready, m_ready);
      chk("remaining", remaining, m_ready ? m_deck.size() : 0);
      chk("shuffle_rst", shuffle_rst, exp_rst);
      if (shuffle_rst) chk("seed", seed, exp_seed);
      if (card_valid || player_gnt || dealer_gnt) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant got %b%b%b expected 000", player_gnt, dealer_gnt, card_valid);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("card_out", card_out, e.card);
          chk("card_dest", card_dest, e.dest);
          chk("gnt_valid", {player_gnt, dealer_gnt, card_valid}, {!e.dest, e.dest, 1'b1});
`ifdef DECK_CARD_VALUE_EN
          chk("card_value", card_value, val_of(e.card));
`endif
        end
      end else if (sbq.size() != 0) begin
        checks++; errors++;
        $display("FAIL missing_grant got 0 expected card %0d", sbq[0].card);
        sbq.delete();
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1;
    wait_count(17);
    wait_ready(0);
    repeat (4) tick(1, 1, 0);
    tick(0, 0, 0);
    chk("hold_remaining", remaining, 48);
    draw_below(16);
    tick(0, 0, 0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 1);
    wait_ready(0);
    draw_below(1);
    tick(1, 0, 0);
    tick(1, 0, 0);
    wait_ready(1);
    draw_below(15);
    wait_count(0);
    wait_ready(0);
    fault = 1;
    draw_below(15);
    tick(0, 0, 1);
    wait_ready(0);
    draw_below(15);
    tick(0, 0, 1);
    for (int k = 0; k < 400 && !(ld_active && li >= 30); k++) tick(0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    chk_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_count(5);
    wait_ready(0);
    repeat (30) tick($urandom % 2, $urandom % 2, 0);
    repeat (3) tick(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
